// File: rtl/y86_mem_pkg.sv
// Shared types and constants for the Y86 unified-memory arbiter.
// Holds the FSM state encoding, pipeline status codes and the command payload.
package y86_mem_pkg;

    localparam int unsigned FETCH_BYTES = 10;
    localparam int unsigned DATA_BYTES  = 8;
    localparam int unsigned FETCH_W     = 8 * FETCH_BYTES;
    localparam int unsigned DATA_W      = 8 * DATA_BYTES;
    localparam int unsigned SIZE_W      = 4;
    localparam int unsigned WDOG_W      = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_F_BUSY  = 2'd1,
        ST_M_BUSY  = 2'd2,
        ST_F_DRAIN = 2'd3
    } arb_state_e;

    // Pipeline status codes; an arbiter error is reported to the pipeline as STAT_ADR.
    typedef enum logic [3:0] {
        STAT_AOK = 4'h1,
        STAT_HLT = 4'h2,
        STAT_ADR = 4'h3,
        STAT_INS = 4'h4
    } stat_e;

    typedef struct packed {
        logic              we;
        logic [SIZE_W-1:0] size;
        logic [DATA_W-1:0] wdata;
    } mem_cmd_t;

endpackage

// File: rtl/y86_mem_arbiter_if.sv
// Bundle of fetch-stage, memory-stage and memory-side signals around the arbiter.
// master is the arbiter's view; slave is the pipeline/memory view.
interface y86_mem_arbiter_if #(
    parameter int unsigned ADDR_W = 64
);
    import y86_mem_pkg::*;

    logic                  f_req;
    logic [ADDR_W-1:0]     f_addr;
    logic [FETCH_W-1:0]    f_rdata;
    logic                  f_done;
    logic                  f_err;
    logic                  f_stall;

    logic                  m_req;
    logic                  m_we;
    logic [ADDR_W-1:0]     m_addr;
    logic [DATA_W-1:0]     m_wdata;
    logic [DATA_W-1:0]     m_rdata;
    logic                  m_done;
    logic                  m_err;
    logic                  m_stall;

    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [SIZE_W-1:0]     mem_size;
    logic                  mem_ack;
    logic                  mem_err;
    logic [FETCH_W-1:0]    mem_rdata;

    modport master (
        input  f_req, f_addr,
        output f_rdata, f_done, f_err, f_stall,
        input  m_req, m_we, m_addr, m_wdata,
        output m_rdata, m_done, m_err, m_stall,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_size,
        input  mem_ack, mem_err, mem_rdata
    );

    modport slave (
        output f_req, f_addr,
        input  f_rdata, f_done, f_err, f_stall,
        output m_req, m_we, m_addr, m_wdata,
        input  m_rdata, m_done, m_err, m_stall,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_size,
        output mem_ack, mem_err, mem_rdata
    );

endinterface

// File: rtl/mem_wdog.sv
// Busy-cycle watchdog: counts cycles spent waiting for mem_ack and flags
// expiry once the count reaches LIMIT.
module mem_wdog
    import y86_mem_pkg::*;
#(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);

    logic [WDOG_W-1:0] count;

    assign expired = (count == WDOG_W'(LIMIT));

    // Count holds at LIMIT so a late ack still sees expiry rather than a wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run && !expired) begin
            count <= count + WDOG_W'(1);
        end
    end

endmodule

// File: rtl/y86_mem_arbiter.sv
// Arbitrates the single-ported unified memory between fetch and memory stages,
// holding each request until ack or watchdog abort and returning registered data.
module y86_mem_arbiter
    import y86_mem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 64,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic               clk,
    input  logic               rst,
    y86_mem_arbiter_if.master  bus
);

    arb_state_e        state;
    arb_state_e        state_next;

    logic              last_m;
    logic              grant_f;
    logic              grant_m;
    logic              fin_f;
    logic              fin_m;
    logic              fin_err;
    logic              cap_f;
    logic              cap_m;
    logic              wd_clear;
    logic              wd_run;
    logic              wd_expired;

    logic [ADDR_W-1:0] addr_next;
    mem_cmd_t          cmd_next;

    mem_wdog #(
        .LIMIT (TIMEOUT_CYC)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (wd_clear),
        .run     (wd_run),
        .expired (wd_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Grant, completion, cancel and abort decisions.
    always_comb begin
        state_next = state;
        grant_f    = 1'b0;
        grant_m    = 1'b0;
        fin_f      = 1'b0;
        fin_m      = 1'b0;
        fin_err    = 1'b0;
        cap_f      = 1'b0;
        cap_m      = 1'b0;
        wd_clear   = 1'b0;
        wd_run     = 1'b0;

        case (state)
            ST_IDLE: begin
                // last_m hands a tie to fetch after a data access, so fetch never starves.
                if (bus.m_req && (!bus.f_req || !last_m)) begin
                    grant_m    = 1'b1;
                    wd_clear   = 1'b1;
                    state_next = ST_M_BUSY;
                end else if (bus.f_req) begin
                    grant_f    = 1'b1;
                    wd_clear   = 1'b1;
                    state_next = ST_F_BUSY;
                end
            end

            ST_F_BUSY: begin
                if (!bus.f_req) begin
                    // Flushed fetch: finish the memory handshake silently.
                    if (bus.mem_ack || wd_expired) begin
                        state_next = ST_IDLE;
                    end else begin
                        wd_clear   = 1'b1;
                        state_next = ST_F_DRAIN;
                    end
                end else if (bus.mem_ack) begin
                    cap_f      = 1'b1;
                    fin_f      = 1'b1;
                    fin_err    = bus.mem_err;
                    state_next = ST_IDLE;
                end else if (wd_expired) begin
                    fin_f      = 1'b1;
                    fin_err    = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    wd_run = 1'b1;
                end
            end

            ST_M_BUSY: begin
                // m_req is deliberately not looked at: a started data access always completes.
                if (bus.mem_ack) begin
                    cap_m      = !bus.mem_we;
                    fin_m      = 1'b1;
                    fin_err    = bus.mem_err;
                    state_next = ST_IDLE;
                end else if (wd_expired) begin
                    fin_m      = 1'b1;
                    fin_err    = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    wd_run = 1'b1;
                end
            end

            ST_F_DRAIN: begin
                if (bus.mem_ack || wd_expired) begin
                    state_next = ST_IDLE;
                end else begin
                    wd_run = 1'b1;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Request payload for the winner; otherwise hold what is on the bus.
    always_comb begin
        addr_next      = bus.mem_addr;
        cmd_next.we    = bus.mem_we;
        cmd_next.size  = bus.mem_size;
        cmd_next.wdata = bus.mem_wdata;
        if (grant_m) begin
            addr_next      = bus.m_addr;
            cmd_next.we    = bus.m_we;
            cmd_next.size  = SIZE_W'(DATA_BYTES);
            cmd_next.wdata = bus.m_wdata;
        end else if (grant_f) begin
            addr_next      = bus.f_addr;
            cmd_next.we    = 1'b0;
            cmd_next.size  = SIZE_W'(FETCH_BYTES);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_size  <= '0;
        end else begin
            bus.mem_req   <= (state_next != ST_IDLE);
            bus.mem_we    <= cmd_next.we;
            bus.mem_addr  <= addr_next;
            bus.mem_wdata <= cmd_next.wdata;
            bus.mem_size  <= cmd_next.size;
        end
    end

    // Completion pulses, read data capture and fairness history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.f_done  <= 1'b0;
            bus.f_err   <= 1'b0;
            bus.m_done  <= 1'b0;
            bus.m_err   <= 1'b0;
            bus.f_rdata <= '0;
            bus.m_rdata <= '0;
            last_m      <= 1'b0;
        end else begin
            bus.f_done <= fin_f;
            bus.f_err  <= fin_f & fin_err;
            bus.m_done <= fin_m;
            bus.m_err  <= fin_m & fin_err;
            if (cap_f) begin
                bus.f_rdata <= bus.mem_rdata;
            end
            if (cap_m) begin
                bus.m_rdata <= bus.mem_rdata[DATA_W-1:0];
            end
            if (fin_m) begin
                last_m <= 1'b1;
            end else if (fin_f) begin
                last_m <= 1'b0;
            end
        end
    end

    assign bus.f_stall = bus.f_req & ~bus.f_done;
    assign bus.m_stall = bus.m_req & ~bus.m_done;

endmodule
